// File: rtl/hazard_scoreboard_pkg.sv
// Shared sizes, latency encodings and helpers for the register hazard scoreboard.
package hazard_scoreboard_pkg;
    localparam int REG_W     = 3;
    localparam int NREG      = 8;
    localparam int MAX_LOADS = 2;

    typedef enum logic [1:0] {
        LAT_FWD = 2'd0,
        LAT_1   = 2'd1,
        LAT_2   = 2'd2,
        LAT_VAR = 2'd3
    } lat_e;

    function automatic logic [NREG-1:0] onehot(input logic [REG_W-1:0] r);
        return NREG'(1) << r;
    endfunction
endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One register's busy tracking: a fixed-latency countdown or an open-ended load slot.
module sb_entry
    import hazard_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic set_fixed,
    input  logic set_var,
    input  lat_e lat,
    input  logic flush,
    input  logic wb_clear,
    output logic busy,
    output logic is_var
);
    logic [1:0] cnt;

    // A new producer outranks a same-cycle writeback clear; flush only drops fixed entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            is_var <= 1'b0;
            cnt    <= 2'd0;
        end else if (set_fixed) begin
            busy   <= 1'b1;
            is_var <= 1'b0;
            cnt    <= lat;
        end else if (set_var) begin
            busy   <= 1'b1;
            is_var <= 1'b1;
            cnt    <= 2'd0;
        end else if (flush && !is_var) begin
            busy <= 1'b0;
            cnt  <= 2'd0;
        end else if (wb_clear) begin
            busy   <= 1'b0;
            is_var <= 1'b0;
        end else if (busy && !is_var && cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
            if (cnt == 2'd1) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: tracks in-flight producers per register and gates issue
// until sources and destination are free, allowing a load writeback to bypass same cycle.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] issue_rs1,
    input  logic [REG_W-1:0] issue_rs2,
    input  logic             issue_use1,
    input  logic             issue_use2,
    input  logic [REG_W-1:0] issue_rd,
    input  logic             issue_wr,
    input  logic [1:0]       issue_lat,
    output logic             issue_ready,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             flush,
    output logic [NREG-1:0]  pending,
    output logic             wb_err
);
    logic [NREG-1:0] busy_v;
    logic [NREG-1:0] var_v;
    logic [NREG-1:0] free_v;
    logic [NREG-1:0] wb_sel;
    logic [1:0]      loads_out;
    logic            wb_hit;
    logic            load_cap;
    logic            accept;
    logic            lat_fixed;
    logic            var_accept;

    assign busy_v[0] = 1'b0;
    assign var_v[0]  = 1'b0;
    assign pending   = busy_v;

    // Only a writeback to a live load entry frees its register in the same cycle.
    always_comb begin
        wb_sel      = onehot(wb_rd);
        wb_hit      = wb_valid && busy_v[wb_rd] && var_v[wb_rd];
        free_v      = ~busy_v | (wb_hit ? wb_sel : '0);
        load_cap    = issue_wr && issue_lat == LAT_VAR &&
                      loads_out == 2'(MAX_LOADS) && !wb_hit;
        issue_ready = (!issue_use1 || free_v[issue_rs1]) &&
                      (!issue_use2 || free_v[issue_rs2]) &&
                      (!issue_wr   || free_v[issue_rd])  && !load_cap;
        accept      = issue_valid && issue_ready && !flush;
        lat_fixed   = issue_lat == LAT_1 || issue_lat == LAT_2;
        var_accept  = accept && issue_wr && issue_rd != '0 && issue_lat == LAT_VAR;
    end

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        sb_entry u_entry (
            .clk       (clk),
            .rst       (rst),
            .set_fixed (accept && issue_wr && lat_fixed && issue_rd == REG_W'(r)),
            .set_var   (var_accept && issue_rd == REG_W'(r)),
            .lat       (lat_e'(issue_lat)),
            .flush     (flush),
            .wb_clear  (wb_hit && wb_sel[r]),
            .busy      (busy_v[r]),
            .is_var    (var_v[r])
        );
    end

    // Outstanding-load count; a simultaneous accept and return cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            loads_out <= 2'd0;
            wb_err    <= 1'b0;
        end else begin
            if (var_accept && !wb_hit)      loads_out <= loads_out + 2'd1;
            else if (!var_accept && wb_hit) loads_out <= loads_out - 2'd1;
            wb_err <= wb_valid && !wb_hit;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized checks of hazard_scoreboard against a cycle-count reference model.
module tb_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic [2:0] issue_rs1;
    logic [2:0] issue_rs2;
    logic       issue_use1;
    logic       issue_use2;
    logic [2:0] issue_rd;
    logic       issue_wr;
    logic [1:0] issue_lat;
    logic       issue_ready;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic       flush;
    logic [7:0] pending;
    logic       wb_err;

    int checks   = 0;
    int failures = 0;

    int m_rem[8];
    bit m_lw[8];
    int m_loads;
    bit m_err;
    bit m_known = 1'b0;

    hazard_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_use1  (issue_use1),
        .issue_use2  (issue_use2),
        .issue_rd    (issue_rd),
        .issue_wr    (issue_wr),
        .issue_lat   (issue_lat),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .flush       (flush),
        .pending     (pending),
        .wb_err      (wb_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input bit v, input int rs1, input bit u1, input int rs2,
                                  input bit u2, input int rd, input bit wr, input int lat);
        issue_valid = v;
        issue_rs1   = 3'(rs1);
        issue_use1  = u1;
        issue_rs2   = 3'(rs2);
        issue_use2  = u2;
        issue_rd    = 3'(rd);
        issue_wr    = wr;
        issue_lat   = 2'(lat);
    endtask

    task automatic set_idle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        wb_valid = 1'b0;
        wb_rd    = 3'd0;
        flush    = 1'b0;
        rst      = 1'b0;
    endtask

    function automatic bit m_free(input int r);
        return (m_rem[r] == 0 && !m_lw[r]) || (m_lw[r] && wb_valid && int'(wb_rd) == r);
    endfunction

    function automatic bit m_ready();
        bit hit;
        hit = wb_valid && m_lw[wb_rd];
        return (!issue_use1 || m_free(int'(issue_rs1))) &&
               (!issue_use2 || m_free(int'(issue_rs2))) &&
               (!issue_wr   || m_free(int'(issue_rd))) &&
               !(issue_wr && issue_lat == 2'd3 && m_loads >= 2 && !hit);
    endfunction

    function automatic logic [7:0] m_pending();
        logic [7:0] p;
        p = 8'h00;
        for (int r = 1; r < 8; r++) p[r] = (m_rem[r] > 0) || m_lw[r];
        return p;
    endfunction

    // Compare the current cycle against the model, then advance both across one edge.
    task automatic cycle_step();
        bit hit;
        bit acc;
        #1;
        if (m_known) begin
            check_output("ready", {7'd0, issue_ready}, {7'd0, m_ready()});
            check_output("pending", pending, m_pending());
            check_output("wb_err", {7'd0, wb_err}, {7'd0, m_err});
        end
        if (rst) begin
            for (int r = 0; r < 8; r++) begin
                m_rem[r] = 0;
                m_lw[r]  = 1'b0;
            end
            m_loads = 0;
            m_err   = 1'b0;
            m_known = 1'b1;
        end else begin
            hit = wb_valid && m_lw[wb_rd];
            acc = issue_valid && m_ready() && !flush;
            for (int r = 1; r < 8; r++)
                if (m_rem[r] > 0) m_rem[r] = flush ? 0 : m_rem[r] - 1;
            m_err = wb_valid && !hit;
            if (hit) begin
                m_lw[wb_rd] = 1'b0;
                m_loads--;
            end
            if (acc && issue_wr && issue_rd != 3'd0) begin
                if (issue_lat == 2'd1 || issue_lat == 2'd2) m_rem[issue_rd] = int'(issue_lat);
                else if (issue_lat == 2'd3) begin
                    m_lw[issue_rd] = 1'b1;
                    m_loads++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle_step();
        rst = 1'b0;
        #1;
        check_output("reset_pending", pending, 8'h00);
        check_output("reset_wb_err", {7'd0, wb_err}, 8'h00);

        // Fixed latency 2 on r3 blocks a consumer for two cycles.
        apply_stimulus(1, 0, 0, 0, 0, 3, 1, 2);
        cycle_step();
        apply_stimulus(1, 3, 1, 0, 0, 0, 0, 0);
        #1;
        check_output("lat2_ready_t1", {7'd0, issue_ready}, 8'h00);
        check_output("lat2_pend_t1", pending, 8'h08);
        cycle_step();
        #1;
        check_output("lat2_ready_t2", {7'd0, issue_ready}, 8'h00);
        check_output("lat2_pend_t2", pending, 8'h08);
        cycle_step();
        #1;
        check_output("lat2_ready_t3", {7'd0, issue_ready}, 8'h01);
        check_output("lat2_pend_t3", pending, 8'h00);
        cycle_step();

        // Load on r5 bypassed by a same-cycle writeback.
        apply_stimulus(1, 0, 0, 0, 0, 5, 1, 3);
        cycle_step();
        set_idle();
        repeat (3) cycle_step();
        check_output("load_pend", pending, 8'h20);
        apply_stimulus(1, 0, 0, 5, 1, 0, 0, 0);
        wb_valid = 1'b1;
        wb_rd    = 3'd5;
        #1;
        check_output("load_bypass_ready", {7'd0, issue_ready}, 8'h01);
        cycle_step();
        set_idle();
        #1;
        check_output("load_cleared", pending, 8'h00);
        check_output("load_no_err", {7'd0, wb_err}, 8'h00);

        // Load cap of two, relieved by a same-cycle writeback.
        apply_stimulus(1, 0, 0, 0, 0, 1, 1, 3);
        cycle_step();
        apply_stimulus(1, 0, 0, 0, 0, 2, 1, 3);
        cycle_step();
        apply_stimulus(1, 0, 0, 0, 0, 4, 1, 3);
        #1;
        check_output("cap_ready", {7'd0, issue_ready}, 8'h00);
        wb_valid = 1'b1;
        wb_rd    = 3'd1;
        #1;
        check_output("cap_relief_ready", {7'd0, issue_ready}, 8'h01);
        cycle_step();
        wb_valid = 1'b0;
        apply_stimulus(1, 0, 0, 0, 0, 6, 1, 3);
        #1;
        check_output("cap_pend", pending, 8'h14);
        check_output("cap_still_full", {7'd0, issue_ready}, 8'h00);
        set_idle();
        wb_valid = 1'b1;
        wb_rd    = 3'd2;
        cycle_step();
        wb_rd = 3'd4;
        cycle_step();

        // Flush drops fixed entries and keeps the load.
        apply_stimulus(1, 0, 0, 0, 0, 6, 1, 2);
        wb_valid = 1'b0;
        cycle_step();
        apply_stimulus(1, 0, 0, 0, 0, 2, 1, 3);
        cycle_step();
        set_idle();
        flush = 1'b1;
        apply_stimulus(1, 0, 0, 0, 0, 7, 1, 1);
        cycle_step();
        set_idle();
        #1;
        check_output("flush_pend", pending, 8'h04);
        wb_valid = 1'b1;
        wb_rd    = 3'd2;
        cycle_step();
        set_idle();

        // Unexpected writeback and r0 never busy.
        wb_valid = 1'b1;
        wb_rd    = 3'd7;
        cycle_step();
        set_idle();
        #1;
        check_output("err_pulse", {7'd0, wb_err}, 8'h01);
        check_output("err_pend", pending, 8'h00);
        apply_stimulus(1, 0, 0, 0, 0, 0, 1, 3);
        cycle_step();
        set_idle();
        #1;
        check_output("err_one_cycle", {7'd0, wb_err}, 8'h00);
        check_output("r0_not_busy", pending, 8'h00);

        // Reset mid-operation discards everything.
        apply_stimulus(1, 0, 0, 0, 0, 2, 1, 3);
        cycle_step();
        apply_stimulus(1, 0, 0, 0, 0, 3, 1, 2);
        cycle_step();
        set_idle();
        rst = 1'b1;
        cycle_step();
        rst = 1'b0;
        apply_stimulus(1, 2, 1, 3, 1, 3, 1, 3);
        #1;
        check_output("rst_pend", pending, 8'h00);
        check_output("rst_ready", {7'd0, issue_ready}, 8'h01);
        set_idle();
        wb_valid = 1'b1;
        wb_rd    = 3'd2;
        cycle_step();
        set_idle();
        #1;
        check_output("rst_stale_wb_err", {7'd0, wb_err}, 8'h01);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 1),
                           $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                           $urandom_range(0, 3) != 0, $urandom_range(0, 3));
            wb_valid = $urandom_range(0, 9) < 4;
            wb_rd    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0)
                for (int r = 1; r < 8; r++) if (m_lw[r]) wb_rd = 3'(r);
            flush = $urandom_range(0, 19) == 0;
            rst   = $urandom_range(0, 49) == 0;
            cycle_step();
        end
        set_idle();
        cycle_step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
